// File: rtl/snake_mover.sv
// snake_mover: movement stage of the snake datapath.
// Holds the heading, the head position and the body shift register. On each
// step tick the head advances one cell and the body shifts down one slot.
// Growth requests and respawn loads from the collision stage are applied here.
// Optional feature macro: WRAP_AROUND_EN (torus playfield of GRID_W x GRID_H);
// without it coordinates wrap modulo 2^COORD_W.
module snake_mover #(
  parameter int COORD_W = 10,
  parameter int MAX_LEN = 63,
  parameter int LEN_W   = 6,
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int START_X = 32,
  parameter int START_Y = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           step_tick,
  input  logic [1:0]                     dir_in,
  input  logic                           dir_valid,
  input  logic                           grow,
  input  logic                           respawn_vld,
  input  logic [COORD_W-1:0]             respawn_x,
  input  logic [COORD_W-1:0]             respawn_y,
  input  logic [LEN_W-1:0]               respawn_len,
  output logic [COORD_W-1:0]             head_x,
  output logic [COORD_W-1:0]             head_y,
  output logic [COORD_W*(MAX_LEN+1)-1:0] body_x_flat,
  output logic [COORD_W*(MAX_LEN+1)-1:0] body_y_flat,
  output logic [LEN_W-1:0]               snake_length,
  output logic                           moved
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   ONE_LEN_C = LEN_W'(1);

  // Start position is expected to lie on the playfield; this elaboration-time
  // hook is where a parameter sanity check would be attached.
  if ((START_X >= GRID_W) || (START_Y >= GRID_H)) begin : g_start_off_grid
  end

  logic [COORD_W-1:0] r_body_x [0:MAX_LEN];
  logic [COORD_W-1:0] r_body_y [0:MAX_LEN];
  dir_t               r_heading;
  dir_t               r_pend_dir;
  logic               r_pend_vld;
  logic               r_grow_pend;
  logic [LEN_W-1:0]   r_length;
  logic               r_moved;

  logic               w_req_ok;
  dir_t               w_step_dir;
  logic               w_do_step;
  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;
  logic [LEN_W-1:0]   w_len_grown;
  logic [LEN_W-1:0]   w_len_respawn;

  // A request is accepted unless it points straight back along the current heading.
  assign w_req_ok  = dir_valid && (dir_in != (r_heading ^ 2'b10));
  assign w_do_step = step_tick && !respawn_vld;

  // Heading used by this step: same-cycle request wins over a stored pending one.
  always_comb begin
    w_step_dir = r_heading;
    if (w_req_ok) begin
      w_step_dir = dir_t'(dir_in);
    end else if (r_pend_vld) begin
      w_step_dir = r_pend_dir;
    end
  end

  // Next head cell, one unit along the step heading.
  always_comb begin
    w_next_x = r_body_x[0];
    w_next_y = r_body_y[0];
`ifdef WRAP_AROUND_EN
    case (w_step_dir)
      DIR_UP:    w_next_y = (r_body_y[0] == '0) ? COORD_W'(GRID_H - 1) : r_body_y[0] - COORD_W'(1);
      DIR_RIGHT: w_next_x = (r_body_x[0] == COORD_W'(GRID_W - 1)) ? '0 : r_body_x[0] + COORD_W'(1);
      DIR_DOWN:  w_next_y = (r_body_y[0] == COORD_W'(GRID_H - 1)) ? '0 : r_body_y[0] + COORD_W'(1);
      default:   w_next_x = (r_body_x[0] == '0) ? COORD_W'(GRID_W - 1) : r_body_x[0] - COORD_W'(1);
    endcase
`else
    case (w_step_dir)
      DIR_UP:    w_next_y = r_body_y[0] - COORD_W'(1);
      DIR_RIGHT: w_next_x = r_body_x[0] + COORD_W'(1);
      DIR_DOWN:  w_next_y = r_body_y[0] + COORD_W'(1);
      default:   w_next_x = r_body_x[0] - COORD_W'(1);
    endcase
`endif
  end

  // Length after a growing step (saturates) and the clamped respawn length.
  always_comb begin
    w_len_grown = (r_length >= MAX_LEN_C) ? MAX_LEN_C : r_length + ONE_LEN_C;
    if (respawn_len == '0) begin
      w_len_respawn = ONE_LEN_C;
    end else if (respawn_len > MAX_LEN_C) begin
      w_len_respawn = MAX_LEN_C;
    end else begin
      w_len_respawn = respawn_len;
    end
  end

  // Control state: heading, pending heading, pending growth, length, moved pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_heading   <= DIR_RIGHT;
      r_pend_dir  <= DIR_RIGHT;
      r_pend_vld  <= 1'b0;
      r_grow_pend <= 1'b0;
      r_length    <= ONE_LEN_C;
      r_moved     <= 1'b0;
    end else if (respawn_vld) begin
      r_heading   <= DIR_RIGHT;
      r_pend_dir  <= DIR_RIGHT;
      r_pend_vld  <= 1'b0;
      r_grow_pend <= 1'b0;
      r_length    <= w_len_respawn;
      r_moved     <= 1'b0;
    end else if (step_tick) begin
      r_heading   <= w_step_dir;
      r_pend_vld  <= 1'b0;
      r_grow_pend <= 1'b0;
      if (grow || r_grow_pend) begin
        r_length <= w_len_grown;
      end
      r_moved     <= 1'b1;
    end else begin
      if (w_req_ok) begin
        r_pend_dir <= dir_t'(dir_in);
        r_pend_vld <= 1'b1;
      end
      if (grow) begin
        r_grow_pend <= 1'b1;
      end
      r_moved <= 1'b0;
    end
  end

  // Body shift register: slot 0 takes the new head, every other slot its predecessor.
  for (genvar gi = 0; gi <= MAX_LEN; gi++) begin : g_body
    always_ff @(posedge clk) begin
      if (reset) begin
        r_body_x[gi] <= START_X_C;
        r_body_y[gi] <= START_Y_C;
      end else if (respawn_vld) begin
        r_body_x[gi] <= respawn_x;
        r_body_y[gi] <= respawn_y;
      end else if (w_do_step) begin
        if (gi == 0) begin
          r_body_x[gi] <= w_next_x;
          r_body_y[gi] <= w_next_y;
        end else begin
          r_body_x[gi] <= r_body_x[(gi == 0) ? 0 : gi - 1];
          r_body_y[gi] <= r_body_y[(gi == 0) ? 0 : gi - 1];
        end
      end
    end

    assign body_x_flat[gi*COORD_W +: COORD_W] = r_body_x[gi];
    assign body_y_flat[gi*COORD_W +: COORD_W] = r_body_y[gi];
  end

  assign head_x       = r_body_x[0];
  assign head_y       = r_body_y[0];
  assign snake_length = r_length;
  assign moved        = r_moved;

endmodule

// File: tb/tb_snake_mover.sv
// Directed testbench for snake_mover; each scenario task checks its own results.
// Build with +define+WRAP_AROUND_EN to exercise the torus playfield variant.
module tb_snake_mover;

  localparam int COORD_W = 10;
  localparam int MAX_LEN = 63;
  localparam int LEN_W   = 6;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           step_tick;
  logic [1:0]                     dir_in;
  logic                           dir_valid;
  logic                           grow;
  logic                           respawn_vld;
  logic [COORD_W-1:0]             respawn_x;
  logic [COORD_W-1:0]             respawn_y;
  logic [LEN_W-1:0]               respawn_len;
  logic [COORD_W-1:0]             head_x;
  logic [COORD_W-1:0]             head_y;
  logic [COORD_W*(MAX_LEN+1)-1:0] body_x_flat;
  logic [COORD_W*(MAX_LEN+1)-1:0] body_y_flat;
  logic [LEN_W-1:0]               snake_length;
  logic                           moved;

  int n_vec = 0;
  int n_err = 0;

  snake_mover dut (
    .clk          (clk),
    .reset        (reset),
    .step_tick    (step_tick),
    .dir_in       (dir_in),
    .dir_valid    (dir_valid),
    .grow         (grow),
    .respawn_vld  (respawn_vld),
    .respawn_x    (respawn_x),
    .respawn_y    (respawn_y),
    .respawn_len  (respawn_len),
    .head_x       (head_x),
    .head_y       (head_y),
    .body_x_flat  (body_x_flat),
    .body_y_flat  (body_y_flat),
    .snake_length (snake_length),
    .moved        (moved)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [COORD_W-1:0] bx(input int i);
    return body_x_flat[i*COORD_W +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] by(input int i);
    return body_y_flat[i*COORD_W +: COORD_W];
  endfunction

  // Apply one cycle of inputs, sample 1 time unit after the edge, then idle inputs.
  task automatic drive(input logic st, input logic dv, input logic [1:0] d, input logic gr,
                       input logic rv, input int rx, input int ry, input int rl);
    @(negedge clk);
    step_tick   = st;
    dir_valid   = dv;
    dir_in      = d;
    grow        = gr;
    respawn_vld = rv;
    respawn_x   = COORD_W'(rx);
    respawn_y   = COORD_W'(ry);
    respawn_len = LEN_W'(rl);
    @(posedge clk);
    #1;
    step_tick   = 1'b0;
    dir_valid   = 1'b0;
    grow        = 1'b0;
    respawn_vld = 1'b0;
    $display("cycle: st=%0b dv=%0b dir=%0d gr=%0b rv=%0b -> head=(%0d,%0d) len=%0d moved=%0b",
             st, dv, d, gr, rv, head_x, head_y, snake_length, moved);
  endtask

  task automatic test_reset;
    reset = 1'b1; step_tick = 1'b1; dir_valid = 1'b0; dir_in = 2'b00; grow = 1'b1;
    respawn_vld = 1'b0; respawn_x = '0; respawn_y = '0; respawn_len = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; step_tick = 1'b0; grow = 1'b0;
    n_vec++; if (head_x !== 10'd32 || head_y !== 10'd24) begin n_err++;
      $display("FAIL reset_head: got (%0d,%0d) want (32,24)", head_x, head_y); end
    n_vec++; if (bx(63) !== 10'd32 || by(63) !== 10'd24) begin n_err++;
      $display("FAIL reset_body63: got (%0d,%0d) want (32,24)", bx(63), by(63)); end
    n_vec++; if (snake_length !== 6'd1) begin n_err++;
      $display("FAIL reset_len: got %0d want 1", snake_length); end
    n_vec++; if (moved !== 1'b0) begin n_err++;
      $display("FAIL reset_moved: got %0b want 0", moved); end
  endtask

  task automatic test_step;
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd33 || head_y !== 10'd24) begin n_err++;
      $display("FAIL step_head: got (%0d,%0d) want (33,24)", head_x, head_y); end
    n_vec++; if (bx(1) !== 10'd32 || by(1) !== 10'd24) begin n_err++;
      $display("FAIL step_body1: got (%0d,%0d) want (32,24)", bx(1), by(1)); end
    n_vec++; if (snake_length !== 6'd1) begin n_err++;
      $display("FAIL step_len: got %0d want 1", snake_length); end
    n_vec++; if (moved !== 1'b1) begin n_err++;
      $display("FAIL step_moved: got %0b want 1", moved); end
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (moved !== 1'b0 || head_x !== 10'd33) begin n_err++;
      $display("FAIL step_idle: got moved=%0b x=%0d want moved=0 x=33", moved, head_x); end
  endtask

  task automatic test_reverse_ignored;
    drive(0, 1, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd34 || head_y !== 10'd24) begin n_err++;
      $display("FAIL reverse_pending: got (%0d,%0d) want (34,24)", head_x, head_y); end
    drive(1, 1, 2'b11, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd35 || head_y !== 10'd24) begin n_err++;
      $display("FAIL reverse_same_cycle: got (%0d,%0d) want (35,24)", head_x, head_y); end
  endtask

  task automatic test_turn_down;
    drive(1, 1, 2'b10, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd35 || head_y !== 10'd25) begin n_err++;
      $display("FAIL turn_down_head: got (%0d,%0d) want (35,25)", head_x, head_y); end
    n_vec++; if (bx(1) !== 10'd35 || by(1) !== 10'd24) begin n_err++;
      $display("FAIL turn_down_body1: got (%0d,%0d) want (35,24)", bx(1), by(1)); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
      n_vec++; if (moved !== 1'b1 || head_y !== COORD_W'(26 + k)) begin n_err++;
        $display("FAIL b2b_step%0d: got moved=%0b y=%0d want moved=1 y=%0d", k, moved, head_y, 26 + k); end
    end
    n_vec++; if (bx(3) !== 10'd35 || by(3) !== 10'd25) begin n_err++;
      $display("FAIL b2b_body3: got (%0d,%0d) want (35,25)", bx(3), by(3)); end
  endtask

  task automatic test_grow;
    drive(0, 0, 2'b00, 0, 1, 10, 12, 5);
    n_vec++; if (snake_length !== 6'd5 || head_x !== 10'd10 || head_y !== 10'd12 || moved !== 1'b0) begin n_err++;
      $display("FAIL grow_load: got len=%0d (%0d,%0d) moved=%0b want len=5 (10,12) moved=0",
               snake_length, head_x, head_y, moved); end
    drive(1, 0, 2'b00, 1, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd6 || head_x !== 10'd11) begin n_err++;
      $display("FAIL grow_same_cycle: got len=%0d x=%0d want len=6 x=11", snake_length, head_x); end
    drive(0, 0, 2'b00, 1, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd6) begin n_err++;
      $display("FAIL grow_no_step: got %0d want 6", snake_length); end
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd7) begin n_err++;
      $display("FAIL grow_pending: got %0d want 7", snake_length); end
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd7) begin n_err++;
      $display("FAIL grow_consumed: got %0d want 7", snake_length); end
    drive(0, 0, 2'b00, 1, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 0, 1, 10, 12, 3);
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd3) begin n_err++;
      $display("FAIL grow_cleared_by_respawn: got %0d want 3", snake_length); end
  endtask

  task automatic test_grow_saturate;
    drive(0, 0, 2'b00, 0, 1, 20, 20, 63);
    n_vec++; if (snake_length !== 6'd63) begin n_err++;
      $display("FAIL sat_load: got %0d want 63", snake_length); end
    drive(1, 0, 2'b00, 1, 0, 0, 0, 0);
    n_vec++; if (snake_length !== 6'd63) begin n_err++;
      $display("FAIL sat_grow: got %0d want 63", snake_length); end
  endtask

  task automatic test_respawn;
    drive(0, 1, 2'b10, 1, 0, 0, 0, 0);
    drive(1, 1, 2'b00, 1, 1, 10, 12, 0);
    n_vec++; if (head_x !== 10'd10 || head_y !== 10'd12) begin n_err++;
      $display("FAIL respawn_head: got (%0d,%0d) want (10,12)", head_x, head_y); end
    n_vec++; if (bx(1) !== 10'd10 || by(1) !== 10'd12 || bx(63) !== 10'd10 || by(63) !== 10'd12) begin n_err++;
      $display("FAIL respawn_body: got b1=(%0d,%0d) b63=(%0d,%0d) want (10,12)", bx(1), by(1), bx(63), by(63)); end
    n_vec++; if (snake_length !== 6'd1 || moved !== 1'b0) begin n_err++;
      $display("FAIL respawn_len_moved: got len=%0d moved=%0b want len=1 moved=0", snake_length, moved); end
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd11 || head_y !== 10'd12 || snake_length !== 6'd1) begin n_err++;
      $display("FAIL respawn_cleared: got (%0d,%0d) len=%0d want (11,12) len=1", head_x, head_y, snake_length); end
  endtask

  task automatic test_wrap;
    logic [COORD_W-1:0] exp_left, exp_up, exp_right;
`ifdef WRAP_AROUND_EN
    exp_left = 10'd63; exp_up = 10'd47; exp_right = 10'd0;
`else
    exp_left = 10'd1023; exp_up = 10'd1023; exp_right = 10'd64;
`endif
    drive(0, 0, 2'b00, 0, 1, 0, 5, 1);
    drive(0, 1, 2'b00, 0, 0, 0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd0 || head_y !== 10'd4) begin n_err++;
      $display("FAIL wrap_up_pending: got (%0d,%0d) want (0,4)", head_x, head_y); end
    drive(1, 1, 2'b11, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== exp_left || head_y !== 10'd4) begin n_err++;
      $display("FAIL wrap_left: got (%0d,%0d) want (%0d,4)", head_x, head_y, exp_left); end
    drive(0, 0, 2'b00, 0, 1, 7, 0, 1);
    drive(1, 1, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== 10'd7 || head_y !== exp_up) begin n_err++;
      $display("FAIL wrap_up: got (%0d,%0d) want (7,%0d)", head_x, head_y, exp_up); end
    drive(0, 0, 2'b00, 0, 1, 63, 3, 1);
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0);
    n_vec++; if (head_x !== exp_right || head_y !== 10'd3) begin n_err++;
      $display("FAIL wrap_right: got (%0d,%0d) want (%0d,3)", head_x, head_y, exp_right); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_reverse_ignored();
    test_turn_down();
    test_back_to_back();
    test_grow();
    test_grow_saturate();
    test_respawn();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
